// File: rtl/irq_controller.sv
// Purpose: prioritised interrupt controller (edge/level sources, mask, single vectored request).
// Latency: an edge at cycle N shows in pending at N+1 and raises irq at N+2.
// Backpressure: irq is held until irq_ack; no new request is made while a handler is in service.
module irq_controller #(
  parameter int                 NUM_IRQ      = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK    = '1,
  parameter logic [15:0]        VECTOR_BASE  = 16'hFF00,
  parameter int                 VECTOR_SHIFT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               global_en,
  output logic               irq,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic [15:0]        irq_vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service
);

  localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [IDXW-1:0]    win_idx;
  logic               cand_any;
  logic               ack_take;
  logic               irq_q;
  logic               in_service_q;
  logic [15:0]        vec_q;
  logic [15:0]        vec_nxt;

  assign cand     = pend_q & mask;
  assign cand_any = |cand;
  assign rise     = irq_lines & ~prev;
  assign vec_nxt  = VECTOR_BASE + (16'(win_idx) << VECTOR_SHIFT);

  assign irq        = irq_q;
  assign in_service = in_service_q;
  assign irq_vector = vec_q;
  assign pending    = pend_q;

  // Lowest-numbered candidate wins; scan from the top so the lowest set bit is written last.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDXW'(i);
    end
  end

  // Next-state logic; losing the candidate or the master enable withdraws a request even if acked.
  always_comb begin
    state_nxt = state;
    ack_take  = 1'b0;
    case (state)
      IDLE: begin
        if (cand_any && global_en) state_nxt = REQUEST;
      end
      REQUEST: begin
        if (!cand_any || !global_en) begin
          state_nxt = IDLE;
        end else if (irq_ack) begin
          state_nxt = SERVICE;
          ack_take  = 1'b1;
        end
      end
      SERVICE: begin
        if (irq_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge bits latch rises and drop only on their own ack (a same-cycle rise keeps them set); level bits track the line.
  always_comb begin
    ack_clr = '0;
    if (ack_take) ack_clr[win_idx] = 1'b1;
    pend_nxt = (EDGE_MASK & ((pend_q & ~ack_clr) | rise)) | (~EDGE_MASK & irq_lines);
  end

  // State register plus registered irq / in_service decodes of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      irq_q        <= (state_nxt == REQUEST);
      in_service_q <= (state_nxt == SERVICE);
    end
  end

  // Source sampling, pending, mask and vector; prev loads the lines during reset so a held-high input is not an edge.
  always_ff @(posedge clock) begin
    prev <= irq_lines;
    if (reset) begin
      pend_q <= '0;
      mask   <= '0;
      vec_q  <= VECTOR_BASE;
    end else begin
      pend_q <= pend_nxt;
      if (mask_we)  mask  <= mask_wdata;
      if (ack_take) vec_q <= vec_nxt;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Purpose: self-checking bench for irq_controller against a cycle-level behavioural model plus directed scenarios.
// Latency: checks sample outputs at the falling edge after each rising edge.
// Backpressure: ack/done are driven by the bench; every scenario runs a fixed number of cycles.
module tb_irq_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq_lines;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        global_en;
  logic        irq;
  logic        irq_ack;
  logic        irq_done;
  logic [15:0] irq_vector;
  logic [7:0]  pending;
  logic        in_service;

  logic [15:0] lines16;
  logic        mask16_we;
  logic [15:0] mask16_wdata;
  logic        ge16;
  logic        irq16;
  logic        ack16;
  logic        done16;
  logic [15:0] vec16;
  logic [15:0] pend16;
  logic        insvc16;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state: phase 0 = idle, 1 = requesting, 2 = in service
  int        m_state;
  bit [7:0]  m_pend;
  bit [7:0]  m_mask;
  bit [7:0]  m_prev;
  bit [15:0] m_vec;
  bit [7:0]  em = 8'hFE;

  always #5 clock = ~clock;

  irq_controller #(
    .NUM_IRQ(8), .EDGE_MASK(8'hFE), .VECTOR_BASE(16'hFF00), .VECTOR_SHIFT(1)
  ) dut (
    .clock(clock), .reset(reset), .irq_lines(irq_lines), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .global_en(global_en), .irq(irq), .irq_ack(irq_ack),
    .irq_done(irq_done), .irq_vector(irq_vector), .pending(pending), .in_service(in_service)
  );

  irq_controller #(
    .NUM_IRQ(16), .EDGE_MASK(16'hFFFF), .VECTOR_BASE(16'hFFF0), .VECTOR_SHIFT(2)
  ) dut16 (
    .clock(clock), .reset(reset), .irq_lines(lines16), .mask_we(mask16_we),
    .mask_wdata(mask16_wdata), .global_en(ge16), .irq(irq16), .irq_ack(ack16),
    .irq_done(done16), .irq_vector(vec16), .pending(pend16), .in_service(insvc16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock of the reference: apply the interrupt rules to the inputs sampled at this edge.
  task automatic model_step();
    bit [7:0] cand;
    int       win;
    int       nst;
    bit       take;
    if (reset) begin
      m_state = 0;
      m_pend  = 8'h00;
      m_mask  = 8'h00;
      m_prev  = irq_lines;
      m_vec   = 16'hFF00;
    end else begin
      cand = m_pend & m_mask;
      win  = -1;
      for (int i = 0; i < 8; i++) if (cand[i] && win < 0) win = i;
      take = 1'b0;
      nst  = m_state;
      case (m_state)
        0: if (cand != 0 && global_en) nst = 1;
        1: begin
          if (cand == 0 || !global_en) nst = 0;
          else if (irq_ack) begin nst = 2; take = 1'b1; end
        end
        default: if (irq_done) nst = 0;
      endcase
      for (int i = 0; i < 8; i++) begin
        if (em[i]) m_pend[i] = (m_pend[i] && !(take && win == i)) || (irq_lines[i] && !m_prev[i]);
        else       m_pend[i] = irq_lines[i];
      end
      m_prev = irq_lines;
      if (mask_we) m_mask = mask_wdata;
      if (take) m_vec = 16'hFF00 + 16'(win * 2);
      m_state = nst;
    end
  endtask

  // Advance one cycle and compare every 8-channel output with the model.
  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("irq", irq, m_state == 1);
    chk("in_service", in_service, m_state == 2);
    chk("pending", pending, m_pend);
    chk("irq_vector", irq_vector, m_vec);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; irq_lines = '0; mask_we = 1'b0; mask_wdata = '0; global_en = 1'b0;
    irq_ack = 1'b0; irq_done = 1'b0;
    lines16 = '0; mask16_we = 1'b0; mask16_wdata = '0; ge16 = 1'b0; ack16 = 1'b0; done16 = 1'b0;
    m_state = 0; m_pend = '0; m_mask = '0; m_prev = '0; m_vec = 16'hFF00;

    @(negedge clock);
    steps(3);
    chk("rst_irq", irq, 1'b0);
    chk("rst_insvc", in_service, 1'b0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_vector", irq_vector, 16'hFF00);
    chk("rst_vector16", vec16, 16'hFFF0);
    reset = 1'b0;
    step();

    // 16-channel wrap: channel 15 -> FFF0 + 15*4 = 0x002C
    mask16_we = 1'b1; mask16_wdata = 16'hFFFF; step();
    mask16_we = 1'b0; ge16 = 1'b1; lines16 = 16'h8000; step();
    lines16 = 16'h0000; chk("w16_pend", pend16, 16'h8000); chk("w16_irq_early", irq16, 1'b0);
    step();
    chk("w16_irq", irq16, 1'b1);
    ack16 = 1'b1; step(); ack16 = 1'b0;
    chk("w16_vector", vec16, 16'h002C);
    chk("w16_insvc", insvc16, 1'b1);
    chk("w16_pend_clr", pend16, 16'h0000);
    done16 = 1'b1; step(); done16 = 1'b0;

    // single edge on channel 3: pending next cycle, irq one later, vector FF06 on ack
    mask_we = 1'b1; mask_wdata = 8'hFF; global_en = 1'b1; step();
    mask_we = 1'b0; steps(2);
    irq_lines = 8'h08; step();
    irq_lines = 8'h00;
    chk("e3_pend", pending[3], 1'b1);
    chk("e3_irq_early", irq, 1'b0);
    step();
    chk("e3_irq", irq, 1'b1);
    steps(1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("e3_vector", irq_vector, 16'hFF06);
    chk("e3_pend_clr", pending[3], 1'b0);
    chk("e3_insvc", in_service, 1'b1);
    chk("e3_no_irq", irq, 1'b0);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("e3_stray_ack", irq_vector, 16'hFF06);
    irq_done = 1'b1; step(); irq_done = 1'b0;
    chk("e3_done", in_service, 1'b0);

    // channels 5 and 2 together: 2 first (FF04), then 5 (FF0A)
    irq_lines = 8'h24; step();
    irq_lines = 8'h00; step();
    chk("p_irq1", irq, 1'b1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("p_vec1", irq_vector, 16'hFF04);
    chk("p_pend_left", pending, 8'h20);
    steps(2);
    chk("p_no_nest", irq, 1'b0);
    irq_done = 1'b1; step(); irq_done = 1'b0;
    step();
    chk("p_irq2", irq, 1'b1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("p_vec2", irq_vector, 16'hFF0A);
    irq_done = 1'b1; step(); irq_done = 1'b0;

    // mask cleared while requesting: irq drops within two cycles, pending kept
    irq_lines = 8'h10; step();
    irq_lines = 8'h00; step();
    chk("m_irq", irq, 1'b1);
    mask_we = 1'b1; mask_wdata = 8'h00; step();
    mask_we = 1'b0; step();
    chk("m_irq_drop", irq, 1'b0);
    chk("m_idle", in_service, 1'b0);
    chk("m_pend_kept", pending[4], 1'b1);
    mask_we = 1'b1; mask_wdata = 8'hFF; step();
    mask_we = 1'b0; steps(2);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("m_vec", irq_vector, 16'hFF08);
    irq_done = 1'b1; step(); irq_done = 1'b0;

    // level channel 0 held high re-requests one cycle after returning to idle
    irq_lines = 8'h01; steps(2);
    chk("l_irq", irq, 1'b1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("l_vec", irq_vector, 16'hFF00);
    chk("l_pend_level", pending[0], 1'b1);
    irq_done = 1'b1; step(); irq_done = 1'b0;
    chk("l_idle_irq", irq, 1'b0);
    chk("l_idle_insvc", in_service, 1'b0);
    step();
    chk("l_rereq", irq, 1'b1);
    irq_lines = 8'h00; steps(3);
    chk("l_withdrawn", irq, 1'b0);

    // reset during service with line 1 held high: no request until it falls and rises again
    irq_lines = 8'h02; steps(2);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("r_insvc", in_service, 1'b1);
    reset = 1'b1; steps(2);
    reset = 1'b0;
    mask_we = 1'b1; mask_wdata = 8'hFF; step();
    mask_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r_quiet_irq", irq, 1'b0);
      chk("r_quiet_pend", pending, 8'h00);
    end
    irq_lines = 8'h00; step();
    irq_lines = 8'h02; step();
    step();
    chk("r_new_edge", irq, 1'b1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_done = 1'b1; irq_lines = 8'h00; step(); irq_done = 1'b0;

    // randomized traffic checked against the model every cycle
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) irq_lines[b] = ~irq_lines[b];
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 8'($urandom);
      global_en  = ($urandom_range(0, 9) != 0);
      irq_ack    = ($urandom_range(0, 3) == 0);
      irq_done   = ($urandom_range(0, 4) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
